// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : FIFO of {PC, instruction} pairs between fetch and decode, with
//            valid/ready handshakes on both sides and a redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

  logic [63:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Readiness depends only on occupancy, so a full queue refuses a push
  // even when decode pops in the same cycle.
  assign in_ready  = (r_count != c_full);
  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_mem[r_head][63:32] : 32'h0;
  assign out_instr = out_valid ? r_mem[r_head][31:0]  : 32'h0;
  assign count     = r_count;

  assign w_push = in_valid  & in_ready  & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage carries no reset; validity is tracked by the counter.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_tail] <= {in_pc, in_instr};
  end

endmodule
`default_nettype wire
